// File: rtl/io_input_conditioner.sv
// Two-bank switch conditioner: 2-flop synchronizer, per-bit debounce counter,
// registered rise pulses and a sticky change flag with acknowledge.
module io_input_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] sw0_raw,
    input  logic [WIDTH-1:0] sw1_raw,
    input  logic             changed_ack,
    output logic [WIDTH-1:0] in_port0,
    output logic [WIDTH-1:0] in_port1,
    output logic [WIDTH-1:0] rise0,
    output logic [WIDTH-1:0] rise1,
    output logic             changed
);
    localparam int               NB       = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bank 0 occupies the low WIDTH bits of every packed vector, bank 1 the high bits.
    logic [NB-1:0]    s1_q;
    logic [NB-1:0]    s2_q;
    logic [NB-1:0]    st_q;
    logic [NB-1:0]    st_d;
    logic [NB-1:0]    rise_q;
    logic [NB-1:0]    rise_d;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic             changed_q;
    logic             changed_d;

    always_comb begin
        st_d = st_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != st_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    st_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        rise_d = st_d & ~st_q;
        // A newly accepted change wins over an acknowledge in the same cycle.
        if (st_d != st_q) begin
            changed_d = 1'b1;
        end else if (changed_ack) begin
            changed_d = 1'b0;
        end else begin
            changed_d = changed_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1_q      <= '0;
            s2_q      <= '0;
            st_q      <= '0;
            rise_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= {sw1_raw, sw0_raw};
            s2_q      <= s1_q;
            st_q      <= st_d;
            rise_q    <= rise_d;
            changed_q <= changed_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign in_port0 = st_q[WIDTH-1:0];
    assign in_port1 = st_q[NB-1:WIDTH];
    assign rise0    = rise_q[WIDTH-1:0];
    assign rise1    = rise_q[NB-1:WIDTH];
    assign changed  = changed_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench for io_input_conditioner with DEBOUNCE_CYCLES = 4: expectations
// are queued against absolute edge numbers and compared #1 after that edge.
module tb_io_input_conditioner;
    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int R0 = 2;
    localparam int R1 = 3;
    localparam int CH = 4;

    logic       clock;
    logic       resetn;
    logic [3:0] sw0_raw;
    logic [3:0] sw1_raw;
    logic       changed_ack;
    logic [3:0] in_port0;
    logic [3:0] in_port1;
    logic [3:0] rise0;
    logic [3:0] rise1;
    logic       changed;

    typedef struct {
        int         at;
        int         sel;
        logic [3:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   edge_n      = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    io_input_conditioner #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(16)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .sw0_raw(sw0_raw),
        .sw1_raw(sw1_raw),
        .changed_ack(changed_ack),
        .in_port0(in_port0),
        .in_port1(in_port1),
        .rise0(rise0),
        .rise1(rise1),
        .changed(changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) edge_n <= edge_n + 1;

    function automatic logic [3:0] obs(input int sel);
        case (sel)
            P0:      return in_port0;
            P1:      return in_port1;
            R0:      return rise0;
            R1:      return rise1;
            default: return {3'b000, changed};
        endcase
    endfunction

    task automatic push(input int at, input int sel, input logic [3:0] val, input string name);
        exp_t e;
        int   idx;
        e.at   = at;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        idx    = sb.size();
        while (idx > 0 && sb[idx-1].at > at) idx--;
        sb.insert(idx, e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        exp_t       e;
        logic [3:0] got;
        int         base;
        resetn = 1'b0;
        sw0_raw = 4'hF;
        base = edge_n;
        for (int k = 1; k <= 3; k++) begin
            push(base + k, P0, 4'h0, "reset_in_port0");
            push(base + k, R0, 4'h0, "reset_rise0");
            push(base + k, CH, 4'h0, "reset_changed");
        end
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) resetn = 1'b1;
            if (k == 4) begin
                for (int j = 1; j <= 5; j++) begin
                    push(base + 3 + j, P0, 4'h0, "release_in_port0_wait");
                    push(base + 3 + j, CH, 4'h0, "release_changed_wait");
                end
                push(base + 9, P0, 4'hF, "release_in_port0");
                push(base + 9, R0, 4'hF, "release_rise0");
                push(base + 9, CH, 4'h1, "release_changed");
                push(base + 10, R0, 4'h0, "release_rise0_end");
                push(base + 10, P0, 4'hF, "release_in_port0_hold");
            end
            step();
            while (sb.size() != 0 && sb[0].at <= edge_n) begin
                e = sb.pop_front();
                got = obs(e.sel);
                vectors++;
                if (got !== e.val || e.at != edge_n) begin
                    miscompares++;
                    $display("FAIL %s @edge %0d: got %h, expected %h", e.name, e.at, got, e.val);
                end
            end
        end
    endtask

    task automatic test_clean_step();
        exp_t       e;
        logic [3:0] got;
        int         base;
        base = edge_n;
        push(base + 1, CH, 4'h0, "step_ack_clear");
        for (int k = 1; k <= 5; k++) push(base + k, P1, 4'h0, "step_up_wait");
        push(base + 6, P1, 4'h5, "step_up_in_port1");
        push(base + 6, R1, 4'h5, "step_up_rise1");
        push(base + 6, CH, 4'h1, "step_up_changed");
        push(base + 7, R1, 4'h0, "step_up_rise1_end");
        push(base + 12, P1, 4'h5, "step_down_wait");
        push(base + 13, P1, 4'h0, "step_down_in_port1");
        push(base + 13, R1, 4'h0, "step_down_no_rise");
        push(base + 13, CH, 4'h1, "step_down_changed");
        for (int k = 1; k <= 14; k++) begin
            changed_ack = (k == 1);
            if (k == 1) sw1_raw = 4'h5;
            if (k == 8) sw1_raw = 4'h0;
            step();
            while (sb.size() != 0 && sb[0].at <= edge_n) begin
                e = sb.pop_front();
                got = obs(e.sel);
                vectors++;
                if (got !== e.val || e.at != edge_n) begin
                    miscompares++;
                    $display("FAIL %s @edge %0d: got %h, expected %h", e.name, e.at, got, e.val);
                end
            end
        end
    endtask

    task automatic test_bounce();
        exp_t       e;
        logic [3:0] got;
        int         base;
        sw0_raw = 4'h0;
        for (int k = 1; k <= 8; k++) step();
        changed_ack = 1'b1;
        step();
        changed_ack = 1'b0;
        base = edge_n;
        for (int k = 1; k <= 30; k++) begin
            push(base + k, P0, 4'h0, "bounce_in_port0");
            push(base + k, CH, 4'h0, "bounce_changed");
        end
        push(base + 31, P0, 4'h4, "bounce_accept_in_port0");
        push(base + 31, R0, 4'h4, "bounce_accept_rise0");
        push(base + 31, CH, 4'h1, "bounce_accept_changed");
        push(base + 32, R0, 4'h0, "bounce_rise0_end");
        push(base + 35, P0, 4'h4, "bounce_hold_in_port0");
        for (int k = 1; k <= 35; k++) begin
            if (k <= 25) sw0_raw = (((k - 1) % 5) < 3) ? 4'h4 : 4'h0;
            else         sw0_raw = 4'h4;
            step();
            while (sb.size() != 0 && sb[0].at <= edge_n) begin
                e = sb.pop_front();
                got = obs(e.sel);
                vectors++;
                if (got !== e.val || e.at != edge_n) begin
                    miscompares++;
                    $display("FAIL %s @edge %0d: got %h, expected %h", e.name, e.at, got, e.val);
                end
            end
        end
    endtask

    task automatic test_ack();
        exp_t       e;
        logic [3:0] got;
        int         base;
        base = edge_n;
        for (int k = 1; k <= 6; k++) push(base + k, CH, 4'h0, "ack_clear");
        push(base + 7, CH, 4'h1, "ack_set_priority");
        push(base + 7, R0, 4'h2, "ack_rise0");
        push(base + 7, P0, 4'h6, "ack_in_port0");
        push(base + 8, CH, 4'h0, "ack_next_clear");
        push(base + 8, R0, 4'h0, "ack_rise0_end");
        for (int k = 1; k <= 9; k++) begin
            changed_ack = (k == 1 || k == 7 || k == 8);
            if (k == 2) sw0_raw = 4'h6;
            step();
            while (sb.size() != 0 && sb[0].at <= edge_n) begin
                e = sb.pop_front();
                got = obs(e.sel);
                vectors++;
                if (got !== e.val || e.at != edge_n) begin
                    miscompares++;
                    $display("FAIL %s @edge %0d: got %h, expected %h", e.name, e.at, got, e.val);
                end
            end
        end
        changed_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t       e;
        logic [3:0] got;
        int         base;
        base = edge_n;
        for (int k = 1; k <= 3; k++) push(base + k, P0, 4'h6, "midrst_before");
        for (int k = 4; k <= 5; k++) begin
            push(base + k, P0, 4'h0, "midrst_in_port0");
            push(base + k, R0, 4'h0, "midrst_rise0");
            push(base + k, CH, 4'h0, "midrst_changed");
        end
        for (int k = 6; k <= 10; k++) begin
            push(base + k, P0, 4'h0, "midrst_restart_wait");
            push(base + k, CH, 4'h0, "midrst_changed_wait");
        end
        push(base + 11, P0, 4'h1, "midrst_accept_in_port0");
        push(base + 11, R0, 4'h1, "midrst_accept_rise0");
        push(base + 11, CH, 4'h1, "midrst_accept_changed");
        push(base + 12, R0, 4'h0, "midrst_rise0_end");
        for (int k = 1; k <= 12; k++) begin
            if (k == 1) sw0_raw = 4'h1;
            resetn = !(k == 4 || k == 5);
            step();
            while (sb.size() != 0 && sb[0].at <= edge_n) begin
                e = sb.pop_front();
                got = obs(e.sel);
                vectors++;
                if (got !== e.val || e.at != edge_n) begin
                    miscompares++;
                    $display("FAIL %s @edge %0d: got %h, expected %h", e.name, e.at, got, e.val);
                end
            end
        end
    endtask

    task automatic test_independent();
        exp_t       e;
        logic [3:0] got;
        int         base;
        sw0_raw = 4'h0;
        for (int k = 1; k <= 8; k++) step();
        base = edge_n;
        for (int k = 1; k <= 5; k++) push(base + k, P0, 4'h0, "indep_wait");
        push(base + 6, P0, 4'h1, "indep_bit0_in_port0");
        push(base + 6, R0, 4'h1, "indep_bit0_rise0");
        push(base + 7, P0, 4'h1, "indep_bit0_hold");
        push(base + 7, R0, 4'h0, "indep_rise0_gap");
        push(base + 8, P0, 4'h9, "indep_bit3_in_port0");
        push(base + 8, R0, 4'h8, "indep_bit3_rise0");
        push(base + 8, P1, 4'h0, "indep_in_port1");
        push(base + 9, R0, 4'h0, "indep_rise0_end");
        push(base + 9, P0, 4'h9, "indep_hold");
        for (int k = 1; k <= 9; k++) begin
            if (k == 1) sw0_raw = 4'h1;
            if (k == 3) sw0_raw = 4'h9;
            step();
            while (sb.size() != 0 && sb[0].at <= edge_n) begin
                e = sb.pop_front();
                got = obs(e.sel);
                vectors++;
                if (got !== e.val || e.at != edge_n) begin
                    miscompares++;
                    $display("FAIL %s @edge %0d: got %h, expected %h", e.name, e.at, got, e.val);
                end
            end
        end
    endtask

    initial begin
        resetn      = 1'b0;
        sw0_raw     = 4'h0;
        sw1_raw     = 4'h0;
        changed_ack = 1'b0;
        #1;
        test_reset();
        test_clean_step();
        test_bounce();
        test_ack();
        test_reset_mid();
        test_independent();
        if (sb.size() != 0) begin
            miscompares += sb.size();
            $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
